pc_fetch: RTL and testbench

Program-counter register and instruction-fetch sequencer for the MIPS core. Holds the current PC, drives it out as `addr` to the next-PC logic, and fetches the word at that address from instruction memory. It presents the fetched word to decode with a valid/ready handshake. On each accepted instruction it loads the `npc` value returned by the next-PC logic.

---
 rtl/mips_defs.sv | 19 +
 rtl/pc_reg.sv | 20 ++
 rtl/pc_fetch.sv | 69 ++++++
 tb/tb_pc_fetch.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared constants for the MIPS fetch front end.
// State encoding, widths and the reset PC.
package mips_defs;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  function automatic logic misaligned(input logic [XLEN-1:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program-counter register.
// Loads d when load is high; async reset to RESET_PC.
module pc_reg
  import mips_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RESET_PC;
    else if (load) q <= d;
  end

endmodule

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch sequencer.
// Fetches one word, holds it for decode, then loads npc.
module pc_fetch
  import mips_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] npc,
  output logic [XLEN-1:0] addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] inst,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic            adel,
  output logic [31:0]     inst_count
);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       accept;
  logic       capture;

  assign accept  = (state == S_HOLD) && inst_ready;
  assign capture = (state == S_FETCH) && imem_rvalid;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .d     (npc),
    .q     (addr)
  );

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == S_IDLE):  state_nx = S_FETCH;
      (state == S_FETCH): if (imem_rvalid) state_nx = S_HOLD;
      (state == S_HOLD):
        if (inst_ready)
          state_nx = misaligned(npc) ? S_ERR : S_FETCH;
      default:            state_nx = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      inst       <= '0;
      inst_count <= '0;
    end else begin
      state <= state_nx;
      if (capture) inst <= imem_rdata;
      if (accept) inst_count <= inst_count + 32'd1;
    end
  end

  // Moore outputs only: no path from memory inputs to outputs
  assign imem_req   = (state == S_FETCH);
  assign inst_valid = (state == S_HOLD);
  assign adel       = (state == S_ERR);
  assign imem_addr  = addr;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch.
// Linear steps, immediate assertions at each check.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc;
  logic [31:0] addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        adel;
  logic [31:0] inst_count;

  logic        use_jmp;
  logic [31:0] jmp;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign npc = use_jmp ? jmp : addr + 32'd4;

  pc_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .npc         (npc),
    .addr        (addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .adel        (adel),
    .inst_count  (inst_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " addr"}, addr, 32'h3000);
    chk({tag, " imem_addr"}, imem_addr, 32'h3000);
    chk({tag, " req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, " valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, " adel"}, {31'd0, adel}, 32'd0);
    chk({tag, " inst"}, inst, 32'd0);
    chk({tag, " count"}, inst_count, 32'd0);
  endtask

  task automatic nx;
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b1;
    use_jmp     = 1'b0;
    jmp         = '0;
    nx(); nx();
    chk_reset_outs("reset");

    // zero-wait memory, decode always ready
    imem_rvalid = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      imem_rdata = 32'hA000_0000 + k;
      nx();
      chk("stream req", {31'd0, imem_req}, 32'd1);
      chk("stream addr", imem_addr, 32'h3000 + 4 * k);
      chk("stream valid lo", {31'd0, inst_valid}, 32'd0);
      nx();
      chk("stream valid hi", {31'd0, inst_valid}, 32'd1);
      chk("stream inst", inst, 32'hA000_0000 + k);
      chk("stream req lo", {31'd0, imem_req}, 32'd0);
    end
    nx();
    chk("stream count", inst_count, 32'd3);
    chk("stream next addr", addr, 32'h300C);

    // memory stall then decode backpressure
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready = 1'b0;
    nx();
    chk("rst2 addr", addr, 32'h3000);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nx();
      chk("stall req", {31'd0, imem_req}, 32'd1);
      chk("stall addr", imem_addr, 32'h3000);
      chk("stall valid", {31'd0, inst_valid}, 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    nx();
    chk("late inst", inst, 32'h1234_5678);
    chk("late valid", {31'd0, inst_valid}, 32'd1);
    imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      nx();
      chk("bp valid", {31'd0, inst_valid}, 32'd1);
      chk("bp inst", inst, 32'h1234_5678);
      chk("bp addr", addr, 32'h3000);
      chk("bp req", {31'd0, imem_req}, 32'd0);
      chk("bp count", inst_count, 32'd0);
    end
    imem_rvalid = 1'b0;
    use_jmp = 1'b1;
    jmp = 32'h0000_4000;
    inst_ready = 1'b1;
    nx();
    chk("jump addr", imem_addr, 32'h4000);
    chk("jump req", {31'd0, imem_req}, 32'd1);
    chk("jump count", inst_count, 32'd1);

    // misaligned target
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0000_0042;
    nx();
    chk("mis hold", {31'd0, inst_valid}, 32'd1);
    jmp = 32'h0000_3006;
    nx();
    chk("adel set", {31'd0, adel}, 32'd1);
    chk("adel addr", addr, 32'h3006);
    chk("adel req", {31'd0, imem_req}, 32'd0);
    chk("adel valid", {31'd0, inst_valid}, 32'd0);
    chk("adel count", inst_count, 32'd2);
    use_jmp = 1'b0;
    nx(); nx(); nx();
    chk("adel sticky", {31'd0, adel}, 32'd1);
    chk("adel sticky addr", addr, 32'h3006);
    chk("adel sticky inst", inst, 32'h0000_0042);
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk_reset_outs("adel rst");
    nx();

    // counter wrap
    rst_n = 1'b1;
    nx();
    chk("wrap fetch", {31'd0, imem_req}, 32'd1);
    force dut.inst_count = 32'hFFFF_FFFF;
    #1;
    release dut.inst_count;
    #1;
    chk("wrap preload", inst_count, 32'hFFFF_FFFF);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    nx();
    chk("wrap hold", {31'd0, inst_valid}, 32'd1);
    nx();
    chk("wrap count", inst_count, 32'd0);
    chk("wrap addr", addr, 32'h3004);

    // async reset in FETCH with response pending
    chk("async pre req", {31'd0, imem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("async");
    nx();
    rst_n = 1'b1;
    nx();
    chk("post async req", {31'd0, imem_req}, 32'd1);
    chk("post async valid", {31'd0, inst_valid}, 32'd0);
    chk("post async inst", inst, 32'd0);
    nx();
    chk("post async capture", inst, 32'h5555_AAAA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
